// File: rtl/axi_lite_periph_splitter_if.sv
// Bus bundle for the AXI4-Lite peripheral splitter: one upstream master port (s_*)
// and NUM_SLAVES downstream channels (m_*) sharing address/data lines.
interface axi_lite_periph_splitter_if #(
    parameter int NUM_SLAVES   = 4,
    parameter int SLAVE_ADDR_W = 13
);
    logic                         s_awvalid, s_awready;
    logic [31:0]                  s_awaddr;
    logic                         s_wvalid, s_wready;
    logic [31:0]                  s_wdata;
    logic [3:0]                   s_wstrb;
    logic                         s_bvalid, s_bready;
    logic [1:0]                   s_bresp;
    logic                         s_arvalid, s_arready;
    logic [31:0]                  s_araddr;
    logic                         s_rvalid, s_rready;
    logic [31:0]                  s_rdata;
    logic [1:0]                   s_rresp;

    logic [NUM_SLAVES-1:0]        m_awvalid, m_awready;
    logic [NUM_SLAVES-1:0]        m_wvalid, m_wready;
    logic [NUM_SLAVES-1:0]        m_bvalid, m_bready;
    logic [NUM_SLAVES-1:0]        m_arvalid, m_arready;
    logic [NUM_SLAVES-1:0]        m_rvalid, m_rready;
    logic [SLAVE_ADDR_W-1:0]      m_awaddr, m_araddr;
    logic [31:0]                  m_wdata;
    logic [3:0]                   m_wstrb;
    logic [NUM_SLAVES-1:0][1:0]   m_bresp;
    logic [NUM_SLAVES-1:0][31:0]  m_rdata;
    logic [NUM_SLAVES-1:0][1:0]   m_rresp;

    // Splitter view: accepts s_* requests, issues m_* requests.
    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
        output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
               m_arvalid, m_araddr, m_rready,
        input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
    );

    // Environment view: processor on s_*, peripherals on m_*.
    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
        input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
               m_arvalid, m_araddr, m_rready,
        output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
    );
endinterface

// File: rtl/axi_lite_periph_splitter.sv
// AXI4-Lite 1:N peripheral splitter: address-sliced slave select, DECERR for unmapped
// indices, SLVERR on response timeout. One read and one write outstanding.
module axi_lite_periph_splitter #(
    parameter int NUM_SLAVES     = 4,
    parameter int SLAVE_ADDR_W   = 13,
    parameter int SEL_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      resetn,
    axi_lite_periph_splitter_if.slave bus
);
    localparam int AW    = SLAVE_ADDR_W + SEL_W;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BRSP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RRSP} r_state_e;

    // One-hot slave select; all-zero means the index is unmapped.
    function automatic logic [NUM_SLAVES-1:0] decode(input logic [AW-1:0] addr);
        decode = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            decode[i] = (addr[AW-1 -: SEL_W] == SEL_W'(i));
    endfunction

    w_state_e              w_state_q;
    logic                  aw_done_q, w_done_q, s_awready_q, s_wready_q, s_bvalid_q;
    logic [AW-1:0]         awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            s_bresp_q, bresp_mux;
    logic [NUM_SLAVES-1:0] w_oh_q, m_awvalid_q, m_wvalid_q, m_bready_q, aw_oh, aw_left, w_left;
    logic [CNT_W-1:0]      w_cnt_q;
    logic                  w_to;

    r_state_e              r_state_q;
    logic                  ar_done_q, s_arready_q, s_rvalid_q;
    logic [AW-1:0]         araddr_q;
    logic [31:0]           s_rdata_q, rdata_mux;
    logic [1:0]            s_rresp_q, rresp_mux;
    logic [NUM_SLAVES-1:0] r_oh_q, m_arvalid_q, m_rready_q, ar_oh, ar_left;
    logic [CNT_W-1:0]      r_cnt_q;
    logic                  r_to;

    // Address bits above the selector are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.s_awaddr[31:AW], bus.s_araddr[31:AW]};

    assign aw_oh   = decode(awaddr_q);
    assign ar_oh   = decode(araddr_q);
    assign aw_left = m_awvalid_q & ~bus.m_awready;
    assign w_left  = m_wvalid_q & ~bus.m_wready;
    assign ar_left = m_arvalid_q & ~bus.m_arready;
    assign w_to    = (TIMEOUT_CYCLES != 0) && (w_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign r_to    = (TIMEOUT_CYCLES != 0) && (r_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        bresp_mux = '0;
        rresp_mux = '0;
        rdata_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_oh_q[i]) bresp_mux = bresp_mux | bus.m_bresp[i];
            if (r_oh_q[i]) begin
                rresp_mux = rresp_mux | bus.m_rresp[i];
                rdata_mux = rdata_mux | bus.m_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q   <= W_IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            s_awready_q <= 1'b0;
            s_wready_q  <= 1'b0;
            s_bvalid_q  <= 1'b0;
            s_bresp_q   <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            w_oh_q      <= '0;
            m_awvalid_q <= '0;
            m_wvalid_q  <= '0;
            m_bready_q  <= '0;
            w_cnt_q     <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    m_bready_q <= '1;
                    if (aw_done_q && w_done_q) begin
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        w_cnt_q    <= '0;
                        m_bready_q <= '0;
                        if (|aw_oh) begin
                            w_oh_q      <= aw_oh;
                            m_awvalid_q <= aw_oh;
                            m_wvalid_q  <= aw_oh;
                            w_state_q   <= W_FWD;
                        end else begin
                            s_bvalid_q <= 1'b1;
                            s_bresp_q  <= 2'b11;
                            w_state_q  <= W_BRSP;
                        end
                    end else begin
                        if (bus.s_awvalid && s_awready_q) begin
                            awaddr_q    <= bus.s_awaddr[AW-1:0];
                            aw_done_q   <= 1'b1;
                            s_awready_q <= 1'b0;
                        end else if (!aw_done_q) begin
                            s_awready_q <= 1'b1;
                        end
                        if (bus.s_wvalid && s_wready_q) begin
                            wdata_q    <= bus.s_wdata;
                            wstrb_q    <= bus.s_wstrb;
                            w_done_q   <= 1'b1;
                            s_wready_q <= 1'b0;
                        end else if (!w_done_q) begin
                            s_wready_q <= 1'b1;
                        end
                    end
                end
                W_FWD: begin
                    if (w_to) begin
                        m_awvalid_q <= '0;
                        m_wvalid_q  <= '0;
                        s_bvalid_q  <= 1'b1;
                        s_bresp_q   <= 2'b10;
                        w_state_q   <= W_BRSP;
                    end else begin
                        w_cnt_q     <= w_cnt_q + 1'b1;
                        m_awvalid_q <= aw_left;
                        m_wvalid_q  <= w_left;
                        if (!(|aw_left) && !(|w_left)) begin
                            m_bready_q <= w_oh_q;
                            w_state_q  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (|(bus.m_bvalid & w_oh_q)) begin
                        s_bvalid_q <= 1'b1;
                        s_bresp_q  <= bresp_mux;
                        m_bready_q <= '0;
                        w_state_q  <= W_BRSP;
                    end else if (w_to) begin
                        s_bvalid_q <= 1'b1;
                        s_bresp_q  <= 2'b10;
                        m_bready_q <= '0;
                        w_state_q  <= W_BRSP;
                    end else begin
                        w_cnt_q <= w_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (bus.s_bready) begin
                        s_bvalid_q  <= 1'b0;
                        s_awready_q <= 1'b1;
                        s_wready_q  <= 1'b1;
                        m_bready_q  <= '1;
                        w_state_q   <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q   <= R_IDLE;
            ar_done_q   <= 1'b0;
            s_arready_q <= 1'b0;
            s_rvalid_q  <= 1'b0;
            s_rresp_q   <= '0;
            s_rdata_q   <= '0;
            araddr_q    <= '0;
            r_oh_q      <= '0;
            m_arvalid_q <= '0;
            m_rready_q  <= '0;
            r_cnt_q     <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    m_rready_q <= '1;
                    if (ar_done_q) begin
                        ar_done_q  <= 1'b0;
                        r_cnt_q    <= '0;
                        m_rready_q <= '0;
                        if (|ar_oh) begin
                            r_oh_q      <= ar_oh;
                            m_arvalid_q <= ar_oh;
                            r_state_q   <= R_ADDR;
                        end else begin
                            s_rvalid_q <= 1'b1;
                            s_rresp_q  <= 2'b11;
                            s_rdata_q  <= '0;
                            r_state_q  <= R_RRSP;
                        end
                    end else if (bus.s_arvalid && s_arready_q) begin
                        araddr_q    <= bus.s_araddr[AW-1:0];
                        ar_done_q   <= 1'b1;
                        s_arready_q <= 1'b0;
                    end else begin
                        s_arready_q <= 1'b1;
                    end
                end
                R_ADDR: begin
                    if (r_to) begin
                        m_arvalid_q <= '0;
                        s_rvalid_q  <= 1'b1;
                        s_rresp_q   <= 2'b10;
                        s_rdata_q   <= '0;
                        r_state_q   <= R_RRSP;
                    end else begin
                        r_cnt_q     <= r_cnt_q + 1'b1;
                        m_arvalid_q <= ar_left;
                        if (!(|ar_left)) begin
                            m_rready_q <= r_oh_q;
                            r_state_q  <= R_DATA;
                        end
                    end
                end
                R_DATA: begin
                    if (|(bus.m_rvalid & r_oh_q)) begin
                        s_rvalid_q <= 1'b1;
                        s_rresp_q  <= rresp_mux;
                        s_rdata_q  <= rdata_mux;
                        m_rready_q <= '0;
                        r_state_q  <= R_RRSP;
                    end else if (r_to) begin
                        s_rvalid_q <= 1'b1;
                        s_rresp_q  <= 2'b10;
                        s_rdata_q  <= '0;
                        m_rready_q <= '0;
                        r_state_q  <= R_RRSP;
                    end else begin
                        r_cnt_q <= r_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (bus.s_rready) begin
                        s_rvalid_q  <= 1'b0;
                        s_arready_q <= 1'b1;
                        m_rready_q  <= '1;
                        r_state_q   <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.s_awready = s_awready_q;
    assign bus.s_wready  = s_wready_q;
    assign bus.s_bvalid  = s_bvalid_q;
    assign bus.s_bresp   = s_bresp_q;
    assign bus.s_arready = s_arready_q;
    assign bus.s_rvalid  = s_rvalid_q;
    assign bus.s_rdata   = s_rdata_q;
    assign bus.s_rresp   = s_rresp_q;
    assign bus.m_awvalid = m_awvalid_q;
    assign bus.m_awaddr  = awaddr_q[SLAVE_ADDR_W-1:0];
    assign bus.m_wvalid  = m_wvalid_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.m_bready  = m_bready_q;
    assign bus.m_arvalid = m_arvalid_q;
    assign bus.m_araddr  = araddr_q[SLAVE_ADDR_W-1:0];
    assign bus.m_rready  = m_rready_q;
endmodule
